// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light R/G/Y interface and its monitor.
package traffic_pkg;

  // Light-sequence segments, in the order they are played.
  typedef enum logic [2:0] {
    SEG_G1 = 3'd0,
    SEG_N1 = 3'd1,
    SEG_G2 = 3'd2,
    SEG_N2 = 3'd3,
    SEG_G3 = 3'd4,
    SEG_Y  = 3'd5,
    SEG_R  = 3'd6
  } seg_e;

  // Monitor tracking state.
  typedef enum logic [1:0] {
    ST_LOCK = 2'd0,
    ST_HUNT = 2'd1,
    ST_DEAD = 2'd2
  } mon_state_e;

  // Colour codes as {R,G,Y}.
  localparam logic [2:0] C_R   = 3'b100;
  localparam logic [2:0] C_G   = 3'b010;
  localparam logic [2:0] C_Y   = 3'b001;
  localparam logic [2:0] C_OFF = 3'b000;

  // Default segment durations in cycles.
  localparam int DEF_G1_CYC = 1024;
  localparam int DEF_N_CYC  = 128;
  localparam int DEF_GS_CYC = 128;
  localparam int DEF_Y_CYC  = 512;
  localparam int DEF_R_CYC  = 1024;
  localparam int DEF_CNT_W  = 16;

  // Expected {R,G,Y} while a segment is playing.
  function automatic logic [2:0] seg_colour(input seg_e s);
    logic [2:0] c;
    c = C_OFF;
    case (s)
      SEG_G1, SEG_G2, SEG_G3: c = C_G;
      SEG_N1, SEG_N2:         c = C_OFF;
      SEG_Y:                  c = C_Y;
      SEG_R:                  c = C_R;
      default:                c = C_OFF;
    endcase
    return c;
  endfunction

  // Segment that follows s; R wraps back to the first green.
  function automatic seg_e next_seg(input seg_e s);
    seg_e n;
    n = SEG_G1;
    case (s)
      SEG_G1:  n = SEG_N1;
      SEG_N1:  n = SEG_G2;
      SEG_G2:  n = SEG_N2;
      SEG_N2:  n = SEG_G3;
      SEG_G3:  n = SEG_Y;
      SEG_Y:   n = SEG_R;
      SEG_R:   n = SEG_G1;
      default: n = SEG_G1;
    endcase
    return n;
  endfunction

  // Segments in which a pedestrian request restarts the sequence.
  function automatic logic pass_restarts(input seg_e s);
    return (s == SEG_N1) || (s == SEG_G2) || (s == SEG_N2) || (s == SEG_G3);
  endfunction

endpackage

// File: rtl/tl_ref_model.sv
// Reference sequence generator: tracks the expected segment and the cycle
// position inside it, and presents the colour the controller should drive.
module tl_ref_model
  import traffic_pkg::*;
#(
  parameter int G1_CYC = DEF_G1_CYC,
  parameter int N_CYC  = DEF_N_CYC,
  parameter int GS_CYC = DEF_GS_CYC,
  parameter int Y_CYC  = DEF_Y_CYC,
  parameter int R_CYC  = DEF_R_CYC,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pass,
  input  logic       load,
  input  logic       en,
  output logic [2:0] seg,
  output logic [2:0] exp_rgy
);

  // Last count value of each segment; durations must fit in CNT_W bits.
  localparam logic [CNT_W-1:0] G1_LAST = CNT_W'(G1_CYC - 1);
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N_CYC - 1);
  localparam logic [CNT_W-1:0] GS_LAST = CNT_W'(GS_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(Y_CYC - 1);
  localparam logic [CNT_W-1:0] R_LAST  = CNT_W'(R_CYC - 1);

  seg_e             seg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] seg_last;

  // Duration lookup for the segment currently being played.
  always_comb begin
    seg_last = G1_LAST;
    case (seg_q)
      SEG_G1:         seg_last = G1_LAST;
      SEG_N1, SEG_N2: seg_last = N_LAST;
      SEG_G2, SEG_G3: seg_last = GS_LAST;
      SEG_Y:          seg_last = Y_LAST;
      SEG_R:          seg_last = R_LAST;
      default:        seg_last = G1_LAST;
    endcase
  end

  // Advance segment/count; load and a restarting pass both jump to G1 count 0,
  // and pass takes priority over the end-of-segment advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_G1;
      cnt_q <= '0;
    end else if (load) begin
      seg_q <= SEG_G1;
      cnt_q <= '0;
    end else if (en) begin
      if (pass && pass_restarts(seg_q)) begin
        seg_q <= SEG_G1;
        cnt_q <= '0;
      end else if (cnt_q == seg_last) begin
        seg_q <= next_seg(seg_q);
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign seg     = seg_q;
  assign exp_rgy = seg_colour(seg_q);

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic light R/G/Y outputs. Compares the
// observed colours against a local reference sequence, counts mismatches and
// re-acquires alignment on the next red-to-green edge when RESYNC is set.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int G1_CYC = DEF_G1_CYC,
  parameter int N_CYC  = DEF_N_CYC,
  parameter int GS_CYC = DEF_GS_CYC,
  parameter int Y_CYC  = DEF_Y_CYC,
  parameter int R_CYC  = DEF_R_CYC,
  parameter int CNT_W  = DEF_CNT_W,
  parameter bit RESYNC = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pass,
  input  logic             R,
  input  logic             G,
  input  logic             Y,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             locked,
  output logic [2:0]       seg
);

  mon_state_e state;
  logic       saw_r;
  logic [2:0] obs;
  logic [2:0] exp_rgy;
  logic       mismatch;
  logic       model_load;
  logic       model_en;
  logic       model_pass;
  logic       g_edge;

  assign obs      = {R, G, Y};
  // Illegal multi-colour codes never equal an expected colour, so they
  // fall out of the plain compare.
  assign mismatch = (obs != exp_rgy);
  // A green sample right after a red one marks the start of G1.
  assign g_edge   = saw_r && (obs == C_G);

  // Reference model control: free-run while locked; while hunting, park the
  // model at G1/0 on every red sample and release it on the green edge so
  // the first locked sample expects G1 count 1.
  always_comb begin
    model_load = 1'b0;
    model_en   = 1'b0;
    model_pass = 1'b0;
    case (state)
      ST_LOCK: begin
        model_en   = 1'b1;
        model_pass = pass;
      end
      ST_HUNT: begin
        model_load = R;
        model_en   = g_edge;
      end
      default: begin
        model_load = 1'b0;
        model_en   = 1'b0;
      end
    endcase
  end

  tl_ref_model #(
    .G1_CYC (G1_CYC),
    .N_CYC  (N_CYC),
    .GS_CYC (GS_CYC),
    .Y_CYC  (Y_CYC),
    .R_CYC  (R_CYC),
    .CNT_W  (CNT_W)
  ) u_ref (
    .clk     (clk),
    .rst_n   (rst_n),
    .pass    (model_pass),
    .load    (model_load),
    .en      (model_en),
    .seg     (seg),
    .exp_rgy (exp_rgy)
  );

  // Lock/hunt/dead tracking with registered err pulse, saturating counter
  // and lock flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_LOCK;
      err     <= 1'b0;
      err_cnt <= '0;
      locked  <= 1'b1;
      saw_r   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_LOCK: begin
          if (mismatch) begin
            err    <= 1'b1;
            locked <= 1'b0;
            saw_r  <= 1'b0;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            state  <= RESYNC ? ST_HUNT : ST_DEAD;
          end
        end
        ST_HUNT: begin
          saw_r <= R;
          if (g_edge) begin
            state  <= ST_LOCK;
            locked <= 1'b1;
          end
        end
        ST_DEAD: begin
          locked <= 1'b0;
        end
        default: begin
          state  <= ST_DEAD;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: a golden controller plus fault injection
// drives three monitor instances (default, small non-resync, small resync),
// with expectations from a phase-position model of the light sequence.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  rgy [3];
  logic        pas [3];
  logic        err_o [3];
  logic        locked_o [3];
  logic [2:0]  seg_o [3];
  logic [15:0] cnt_o [3];
  logic [15:0] cnt0;
  logic [3:0]  cnt1, cnt2;

  int checks = 0;
  int errors = 0;
  int n = 0;

  // Model configuration per instance.
  int cfg_d [3][7];
  int cmax [3];
  bit cres [3];

  // Model state: monitor position, lock/hunt flags, err, count; golden position.
  int mp [3];
  bit ml [3];
  bit msaw [3];
  bit merr [3];
  int mcnt [3];
  int gp [3];

  always #5 clk = ~clk;

  traffic_light_monitor dut0 (
    .clk(clk), .rst_n(rst_n), .pass(pas[0]),
    .R(rgy[0][2]), .G(rgy[0][1]), .Y(rgy[0][0]),
    .err(err_o[0]), .err_cnt(cnt0), .locked(locked_o[0]), .seg(seg_o[0]));

  traffic_light_monitor #(
    .G1_CYC(8), .N_CYC(2), .GS_CYC(3), .Y_CYC(4), .R_CYC(6), .CNT_W(4), .RESYNC(1'b0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pass(pas[1]),
    .R(rgy[1][2]), .G(rgy[1][1]), .Y(rgy[1][0]),
    .err(err_o[1]), .err_cnt(cnt1), .locked(locked_o[1]), .seg(seg_o[1]));

  traffic_light_monitor #(
    .G1_CYC(8), .N_CYC(2), .GS_CYC(3), .Y_CYC(4), .R_CYC(6), .CNT_W(4), .RESYNC(1'b1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .pass(pas[2]),
    .R(rgy[2][2]), .G(rgy[2][1]), .Y(rgy[2][0]),
    .err(err_o[2]), .err_cnt(cnt2), .locked(locked_o[2]), .seg(seg_o[2]));

  assign cnt_o[0] = cnt0;
  assign cnt_o[1] = {12'd0, cnt1};
  assign cnt_o[2] = {12'd0, cnt2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  function automatic int period(input int k);
    int acc = 0;
    for (int s = 0; s < 7; s++) acc += cfg_d[k][s];
    return acc;
  endfunction

  // Segment index for a position measured from the start of G1.
  function automatic int seg_of(input int k, input int p);
    int acc = 0;
    for (int s = 0; s < 7; s++) begin
      acc += cfg_d[k][s];
      if (p < acc) return s;
    end
    return 0;
  endfunction

  function automatic logic [2:0] colour(input int s);
    if (s == 0 || s == 2 || s == 4) return 3'b010;
    if (s == 5) return 3'b001;
    if (s == 6) return 3'b100;
    return 3'b000;
  endfunction

  function automatic int advance(input int k, input int p, input logic ps);
    int s = seg_of(k, p);
    if (ps && s >= 1 && s <= 4) return 0;
    return (p + 1) % period(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mp[k] = 0; ml[k] = 1'b1; msaw[k] = 1'b0; merr[k] = 1'b0; mcnt[k] = 0; gp[k] = 0;
    end
  endtask

  // One sample of instance k with observed colour o and request p.
  task automatic step(input int k, input logic [2:0] o, input logic p);
    merr[k] = 1'b0;
    gp[k] = advance(k, gp[k], p);
    if (ml[k]) begin
      if (o != colour(seg_of(k, mp[k]))) begin
        merr[k] = 1'b1;
        if (mcnt[k] < cmax[k]) mcnt[k]++;
        ml[k] = 1'b0;
        msaw[k] = 1'b0;
      end
      mp[k] = advance(k, mp[k], p);
    end else if (cres[k]) begin
      if (msaw[k] && o == 3'b010) begin
        ml[k] = 1'b1;
        mp[k] = 1;
      end
      msaw[k] = o[2];
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("k%0d n%0d status", k, n),
          {14'd0, err_o[k], locked_o[k], cnt_o[k]},
          {14'd0, merr[k], ml[k], 16'(mcnt[k])});
      if (ml[k])
        chk($sformatf("k%0d n%0d seg", k, n), {29'd0, seg_o[k]}, 32'(seg_of(k, mp[k])));
    end
  endtask

  // Called at a falling edge: hold reset 3 cycles, checking reset values.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
    n = 0;
  endtask

  task automatic run(input int ncyc, input int phase);
    bit did_rst = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      logic [2:0] o;
      logic       p;
      logic [2:0] gold;
      @(negedge clk);
      check_all();
      if (i == 0) do_reset();
      if (phase == 3 && n == 1500 && !did_rst) begin
        did_rst = 1'b1;
        do_reset();
      end
      for (int k = 0; k < 3; k++) begin
        gold = colour(seg_of(k, gp[k]));
        o = gold;
        p = 1'b0;
        if (k == 0) begin
          if (phase == 1)
            p = (n == 500) || (n == 1100) ||
                (n >= 2000 && n < 4000 && gp[0] == 1535) ||
                (n >= 4000 && gp[0] == 2800);
          if (phase == 2 && n == 200) o = 3'b001;
          if (phase == 3) begin
            p = ($urandom_range(63) == 0);
            if ($urandom_range(499) == 0) o = 3'($urandom_range(7));
          end
        end else if (k == 1) begin
          p = ($urandom_range(15) == 0);
          if (n >= 10) o = 3'b111;
        end else begin
          p = ($urandom_range(15) == 0);
          if ($urandom_range(3) == 0) o = 3'($urandom_range(7));
        end
        rgy[k] = o;
        pas[k] = p;
        step(k, o, p);
      end
      n++;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    cfg_d[0] = '{1024, 128, 128, 128, 128, 512, 1024};
    cfg_d[1] = '{8, 2, 3, 2, 3, 4, 6};
    cfg_d[2] = '{8, 2, 3, 2, 3, 4, 6};
    cmax = '{65535, 15, 15};
    cres = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      rgy[k] = 3'b010;
      pas[k] = 1'b0;
    end
    model_reset();

    // Golden controller, no requests: two full wraps.
    run(8200, 0);
    chk("idle_cnt", {16'd0, cnt0}, 32'd0);
    chk("idle_locked", {31'd0, locked_o[0]}, 32'd1);

    // Requests in N1, G1, R and the last cycle of G3.
    run(8000, 1);
    chk("pass_cnt", {16'd0, cnt0}, 32'd0);

    // Single Y fault in G1, relock on the next R->G edge.
    run(4000, 2);
    chk("fault_cnt", {16'd0, cnt0}, 32'd1);
    chk("fault_relock", {31'd0, locked_o[0]}, 32'd1);

    // Random traffic with a mid-run reset.
    run(3500, 3);
    chk("dead_cnt", {28'd0, cnt1}, 32'd1);
    chk("dead_locked", {31'd0, locked_o[1]}, 32'd0);
    chk("sat_cnt", {28'd0, cnt2}, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
